branch_predictor_unit: RTL and testbench
========================================

# branch_predictor_unit

Parametrised dynamic branch predictor for the pipelined OTTER. It is the configurable successor to the fixed 2-bit branch target buffer and adds three things: a tagged direct-mapped BTB, N-bit saturating counters per entry, and a non-speculative return address stack (RAS). Fetch queries it combinationally with the current PC. Execute trains it once per cycle with the resolved outcome of each branch, jump, call or return.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, ≥2. IDX = log2(ENTRIES).
- CTR_BITS, 2: saturating counter width, 1..4.
- TAG_BITS, 8: stored tag width.
- RAS_DEPTH, 4: return stack entries; 0 disables the RAS.

Ports:
- bp_clk  in  1  clock; all state updates on rising edge.
- bp_reset_n  in  1  reset, synchronous, active-low.
- bp_pc  in  32  fetch-stage PC (lookup address).
- bp_pred_taken  out  1  prediction that bp_pc redirects.
- bp_pred_target  out  32  predicted next PC; equals bp_pc+4 when bp_pred_taken=0.
- bp_upd_valid  in  1  training strobe from execute.
- bp_upd_pc  in  32  PC of the resolved instruction.
- bp_upd_target  in  32  resolved target address.
- bp_upd_taken  in  1  resolved direction; must be 1 for kinds other than branch.
- bp_upd_kind  in  2  00 conditional branch, 01 jump (JAL/JALR, not a call or return), 10 call (rd=x1), 11 return (JALR rs1=x1, rd=x0).
- bp_flush  in  1  invalidate all BTB entries and empty the RAS.
- bp_ras_count  out  log2(RAS_DEPTH)+1  current RAS occupancy (debug/verification).

## Operation
- Address split: index = pc[IDX+1:2]; tag = pc[IDX+TAG_BITS+1:IDX+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[31:0], kind[1:0], ctr[CTR_BITS-1:0].
- Lookup (combinational): hit = valid[index] && tag match.
  - Branch entry: taken = ctr MSB.
  - Jump and call entries: taken = 1.
  - Return entry: taken = 1. Target = RAS top if bp_ras_count>0, otherwise the stored target.
  - Miss: not taken, target = bp_pc+4.
- Training, when bp_upd_valid=1 (at the clock edge):
  - Hit, branch: ctr saturating increment if taken, decrement if not taken. Target is rewritten only if taken.
  - Hit, other kinds: target and kind are rewritten, ctr is unchanged.
  - Miss, taken: allocate. Set valid and tag, write target and kind, set ctr = 2^(CTR_BITS-1) (weakly taken). This replaces any aliasing entry.
  - Miss, not-taken branch: no allocation, no state change.
  - CTR_BITS=1: ctr is set on taken and cleared on not-taken.
- RAS (trained from execute, non-speculative):
  - Call: push bp_upd_pc+4.
  - Return: pop.
  - Push when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty: ignored; count stays 0.
  - RAS_DEPTH=0: no stack. Returns always use the stored target, and bp_ras_count=0.
- bp_flush: all valid bits cleared, RAS count set to 0. Counter and target storage may keep stale values, because valid gates every use.
- All target arithmetic is 32-bit modulo 2^32; pc+4 wraps 0xFFFFFFFC to 0x00000000.

## Timing
- Lookup is combinational, with zero-cycle latency from bp_pc to both prediction outputs.
- Training is visible to lookups starting the cycle after the bp_upd_valid edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (no write-through).
- A lookup of a return in the same cycle as a RAS push or pop sees the pre-edge top.
- Priority at an edge: reset > flush > update. An update coinciding with a flush is discarded.
- Reset (bp_reset_n=0 at an edge, including mid-operation): all valid bits 0, RAS count 0. After reset, bp_pred_taken=0, bp_pred_target=bp_pc+4 and bp_ras_count=0, until the first update.
- The predictor has no handshake or stall input; the pipeline is responsible for presenting each resolved instruction exactly once.

## Test plan
Default parameters throughout.
1. Reset, then lookup 0x40 → taken=0, target=0x44, ras_count=0.
2. Allocation and training at 0x40:
   - Update pc=0x40, branch, taken, target=0x20 → next cycle, lookup 0x40 gives taken=1, target=0x20.
   - Two further not-taken updates (ctr 2→1→0) → taken=0, target=0x44.
   - Then three taken updates → ctr saturates at 3, taken=1.
3. Aliasing: with 0x40 allocated, update pc=0x440 (same index 0, tag 0x11) as a taken jump to 0x80.
   - Lookup 0x440 → taken, target 0x80.
   - Lookup 0x40 → miss, target 0x44.
4. Return prediction:
   - Allocate a return at 0x20C with target 0x104, which pops the empty RAS (no-op).
   - Call updates at 0x100 and 0x300 → ras_count=2; lookup 0x20C gives target 0x304.
   - One return update → lookup gives 0x104.
   - Second return update → ras_count=0; lookup falls back to the stored target 0x104.
5. RAS overflow: five calls at 0x10, 0x20, 0x30, 0x40, 0x50 → ras_count=4.
   - Successive pops expose tops 0x54, 0x44, 0x34, 0x24; the value 0x14 is lost.
   - A fifth pop leaves count at 0.
6. Same-cycle and reset boundaries:
   - Update and lookup of 0x40 in the same cycle → lookup shows the old miss.
   - bp_flush together with an update → the update is dropped and all entries are invalid.
   - Reset asserted mid-training sequence → the next lookup misses and ras_count=0.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit
// Dynamic branch predictor for the pipelined OTTER. It holds a tagged, direct-mapped
// BTB with saturating direction counters and a non-speculative return address stack.
// Fetch looks up the PC combinationally, and execute trains the predictor with
// resolved outcomes.
module branch_predictor_unit #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int TAG_BITS  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         bp_clk,
    input  logic                         bp_reset_n,
    input  logic [31:0]                  bp_pc,
    output logic                         bp_pred_taken,
    output logic [31:0]                  bp_pred_target,
    input  logic                         bp_upd_valid,
    input  logic [31:0]                  bp_upd_pc,
    input  logic [31:0]                  bp_upd_target,
    input  logic                         bp_upd_taken,
    input  logic [1:0]                   bp_upd_kind,
    input  logic                         bp_flush,
    output logic [$clog2(RAS_DEPTH):0]   bp_ras_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int RAS_CW = $clog2(RAS_DEPTH) + 1;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_CALL = 2'b10;
    localparam logic [1:0] KIND_RET  = 2'b11;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    // BTB storage. Only valid_q is reset. The other fields are always gated by valid.
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          kind_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // Lookup side
    logic [IDX-1:0]      lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic [31:0]         lk_pc_plus4;

    // Update side
    logic [IDX-1:0]      up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;
    logic                up_accept;
    logic                ent_we;
    logic [31:0]         ent_target_d;
    logic [1:0]          ent_kind_d;
    logic [CTR_BITS-1:0] ent_ctr_d;

    // Return stack view for the lookup path
    logic [31:0] ras_top;
    logic        ras_valid;

    assign lk_idx      = bp_pc[IDX+1:2];
    assign lk_tag      = bp_pc[IDX+TAG_BITS+1:IDX+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_pc_plus4 = bp_pc + 32'd4;

    assign up_idx    = bp_upd_pc[IDX+1:2];
    assign up_tag    = bp_upd_pc[IDX+TAG_BITS+1:IDX+2];
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_accept = bp_upd_valid && !bp_flush;

    // Combinational prediction from the current (pre-edge) BTB and RAS contents
    always_comb begin
        bp_pred_taken  = 1'b0;
        bp_pred_target = lk_pc_plus4;
        if (lk_hit) begin
            case (kind_q[lk_idx])
                KIND_BR: begin
                    if (ctr_q[lk_idx][CTR_BITS-1]) begin
                        bp_pred_taken  = 1'b1;
                        bp_pred_target = target_q[lk_idx];
                    end
                end
                KIND_RET: begin
                    bp_pred_taken  = 1'b1;
                    bp_pred_target = ras_valid ? ras_top : target_q[lk_idx];
                end
                default: begin
                    bp_pred_taken  = 1'b1;
                    bp_pred_target = target_q[lk_idx];
                end
            endcase
        end
    end

    // Training decision: produce the new contents of the indexed entry, or no write
    always_comb begin
        valid_d      = valid_q;
        ent_we       = 1'b0;
        ent_target_d = target_q[up_idx];
        ent_kind_d   = kind_q[up_idx];
        ent_ctr_d    = ctr_q[up_idx];
        if (up_accept) begin
            if (up_hit) begin
                ent_we = 1'b1;
                if (bp_upd_kind == KIND_BR) begin
                    if (bp_upd_taken) begin
                        ent_ctr_d    = (ctr_q[up_idx] != CTR_MAX) ? ctr_q[up_idx] + 1'b1 : ctr_q[up_idx];
                        ent_target_d = bp_upd_target;
                        ent_kind_d   = KIND_BR;
                    end else begin
                        ent_ctr_d = (ctr_q[up_idx] != '0) ? ctr_q[up_idx] - 1'b1 : ctr_q[up_idx];
                    end
                end else begin
                    ent_target_d = bp_upd_target;
                    ent_kind_d   = bp_upd_kind;
                end
            end else if (bp_upd_taken) begin
                // Allocation replaces whatever entry aliases to this index
                ent_we       = 1'b1;
                ent_target_d = bp_upd_target;
                ent_kind_d   = bp_upd_kind;
                ent_ctr_d    = CTR_WEAK;
            end
        end
        if (ent_we) begin
            valid_d[up_idx] = 1'b1;
        end
    end

    // Valid bits: reset and flush clear every entry, and a flush discards a coincident update
    always_ff @(posedge bp_clk) begin
        if (!bp_reset_n || bp_flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Entry payload is written without reset because stale payload is masked by valid
    always_ff @(posedge bp_clk) begin
        if (ent_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= ent_target_d;
            kind_q[up_idx]   <= ent_kind_d;
            ctr_q[up_idx]    <= ent_ctr_d;
        end
    end

    generate
        if (RAS_DEPTH > 0) begin : g_ras
            localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

            logic [31:0]       stack_q [RAS_DEPTH];
            logic [PW-1:0]     ptr_q, ptr_d;
            logic [PW-1:0]     ptr_inc, top_idx;
            logic [RAS_CW-1:0] count_q, count_d;
            logic              ras_push, ras_pop;

            // ptr_q is the next slot to write. The slot before it is the top of the stack.
            assign ras_push  = up_accept && (bp_upd_kind == KIND_CALL);
            assign ras_pop   = up_accept && (bp_upd_kind == KIND_RET);
            assign ptr_inc   = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            assign top_idx   = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;
            assign ras_top   = stack_q[top_idx];
            assign ras_valid = (count_q != '0);
            assign bp_ras_count = count_q;

            // Circular push that overwrites the oldest entry when full, and pop ignored when empty
            always_comb begin
                ptr_d   = ptr_q;
                count_d = count_q;
                if (ras_push) begin
                    ptr_d = ptr_inc;
                    if (count_q != RAS_CW'(RAS_DEPTH)) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (ras_pop && (count_q != '0)) begin
                    ptr_d   = top_idx;
                    count_d = count_q - 1'b1;
                end
            end

            // Stack pointer and occupancy, emptied by reset or flush
            always_ff @(posedge bp_clk) begin
                if (!bp_reset_n || bp_flush) begin
                    ptr_q   <= '0;
                    count_q <= '0;
                end else begin
                    ptr_q   <= ptr_d;
                    count_q <= count_d;
                end
            end

            // Return address written on every accepted call
            always_ff @(posedge bp_clk) begin
                if (ras_push) begin
                    stack_q[ptr_q] <= bp_upd_pc + 32'd4;
                end
            end
        end else begin : g_no_ras
            assign ras_top      = '0;
            assign ras_valid    = 1'b0;
            assign bp_ras_count = '0;
        end
    endgenerate

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit. The driver issues one cycle of
// stimulus and queues the expected outputs. A monitor compares the outputs on
// the falling edge.
module tb_branch_predictor_unit;

    localparam int ENTRIES   = 16;
    localparam int CTR_BITS  = 2;
    localparam int TAG_BITS  = 8;
    localparam int RAS_DEPTH = 4;
    localparam int IDX       = 4;

    logic        bp_clk = 1'b0;
    logic        bp_reset_n;
    logic [31:0] bp_pc;
    logic        bp_pred_taken;
    logic [31:0] bp_pred_target;
    logic        bp_upd_valid;
    logic [31:0] bp_upd_pc;
    logic [31:0] bp_upd_target;
    logic        bp_upd_taken;
    logic [1:0]  bp_upd_kind;
    logic        bp_flush;
    logic [2:0]  bp_ras_count;

    always #5 bp_clk = ~bp_clk;

    branch_predictor_unit #(
        .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .TAG_BITS(TAG_BITS), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .bp_clk(bp_clk),
        .bp_reset_n(bp_reset_n),
        .bp_pc(bp_pc),
        .bp_pred_taken(bp_pred_taken),
        .bp_pred_target(bp_pred_target),
        .bp_upd_valid(bp_upd_valid),
        .bp_upd_pc(bp_upd_pc),
        .bp_upd_target(bp_upd_target),
        .bp_upd_taken(bp_upd_taken),
        .bp_upd_kind(bp_upd_kind),
        .bp_flush(bp_flush),
        .bp_ras_count(bp_ras_count)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        int          count;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: a table of entries plus a plain queue used as the return stack.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_kind  [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_ras[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, expv);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int          idx;
        int unsigned tag;
        idx = int'((pc >> 2) % ENTRIES);
        tag = (pc >> (IDX + 2)) % (1 << TAG_BITS);
        t   = 1'b0;
        tg  = pc + 32'd4;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (m_kind[idx] == 0) begin
                if (m_ctr[idx] >= 2 ** (CTR_BITS - 1)) begin
                    t  = 1'b1;
                    tg = m_tgt[idx];
                end
            end else if (m_kind[idx] == 3) begin
                t  = 1'b1;
                tg = (m_ras.size() > 0) ? m_ras[$] : m_tgt[idx];
            end else begin
                t  = 1'b1;
                tg = m_tgt[idx];
            end
        end
    endfunction

    function automatic void model_train(input logic [31:0] upc, input logic [31:0] utgt,
                                        input bit utk, input int kind);
        int          idx;
        int unsigned tag;
        idx = int'((upc >> 2) % ENTRIES);
        tag = (upc >> (IDX + 2)) % (1 << TAG_BITS);
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (kind == 0) begin
                if (utk) begin
                    if (m_ctr[idx] < 2 ** CTR_BITS - 1) m_ctr[idx]++;
                    m_tgt[idx]  = utgt;
                    m_kind[idx] = 0;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else begin
                m_tgt[idx]  = utgt;
                m_kind[idx] = kind;
            end
        end else if (utk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_tgt[idx]   = utgt;
            m_kind[idx]  = kind;
            m_ctr[idx]   = 2 ** (CTR_BITS - 1);
        end
        if (kind == 2) begin
            m_ras.push_back(upc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (kind == 3 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endfunction

    // One cycle of stimulus. The expectation is either a fixed value or the model's view before the edge.
    task automatic cyc(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input bit utk, input int kind,
                       input bit fl, input bit rn, input bit use_c, input logic ct,
                       input logic [31:0] ctg, input int cc, input string nm);
        exp_t e;
        @(posedge bp_clk);
        #1;
        bp_pc         = pc;
        bp_upd_valid  = uv;
        bp_upd_pc     = upc;
        bp_upd_target = utgt;
        bp_upd_taken  = utk;
        bp_upd_kind   = kind[1:0];
        bp_flush      = fl;
        bp_reset_n    = rn;
        e.nm = nm;
        if (use_c) begin
            e.taken  = ct;
            e.target = ctg;
            e.count  = cc;
        end else begin
            model_lookup(pc, e.taken, e.target);
            e.count = m_ras.size();
        end
        exp_q.push_back(e);
        if (!rn) model_clear();
        else if (fl) model_clear();
        else if (uv) model_train(upc, utgt, utk, kind);
    endtask

    task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                        input int c, input string nm);
        cyc(pc, 0, 32'h0, 32'h0, 0, 0, 0, 1, 1, t, tg, c, nm);
    endtask

    task automatic upd(input logic [31:0] upc, input logic [31:0] utgt, input bit utk, input int kind);
        cyc(upc, 1, upc, utgt, utk, kind, 0, 1, 0, 1'b0, 32'h0, 0, "upd");
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    // Monitor: compares the queued expectation against the outputs at mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge bp_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".taken"},  32'(bp_pred_taken), 32'(e.taken));
                chk({e.nm, ".target"}, bp_pred_target, e.target);
                chk({e.nm, ".ras_count"}, 32'(bp_ras_count), 32'(e.count));
            end
        end
    end

    initial begin
        int wait_cycles;
        bp_reset_n = 1'b0; bp_pc = 32'h0; bp_upd_valid = 1'b0; bp_upd_pc = 32'h0;
        bp_upd_target = 32'h0; bp_upd_taken = 1'b0; bp_upd_kind = 2'b00; bp_flush = 1'b0;
        model_clear();
        repeat (2) @(posedge bp_clk);

        // Reset state and wrap of pc+4
        look(32'h40, 0, 32'h44, 0, "reset_lookup");
        look(32'hFFFF_FFFC, 0, 32'h0, 0, "wrap_pc4");

        // Allocation and counter training
        upd(32'h40, 32'h20, 1, 0);
        look(32'h40, 1, 32'h20, 0, "alloc_taken");
        upd(32'h40, 32'h20, 0, 0);
        upd(32'h40, 32'h20, 0, 0);
        look(32'h40, 0, 32'h44, 0, "ctr_zero");
        repeat (3) upd(32'h40, 32'h20, 1, 0);
        upd(32'h40, 32'h20, 0, 0);
        look(32'h40, 1, 32'h20, 0, "ctr_saturated");

        // Aliasing
        upd(32'h440, 32'h80, 1, 1);
        look(32'h440, 1, 32'h80, 0, "alias_new");
        look(32'h40, 0, 32'h44, 0, "alias_evicted");

        // Return prediction
        upd(32'h20C, 32'h104, 1, 3);
        upd(32'h100, 32'h500, 1, 2);
        upd(32'h300, 32'h600, 1, 2);
        look(32'h20C, 1, 32'h304, 2, "ret_top2");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h104, 1, "ret_top1");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h104, 0, "ret_fallback");

        // RAS overflow and underflow
        for (int i = 1; i <= 5; i++) upd(32'(i * 16), 32'h800, 1, 2);
        look(32'h20C, 1, 32'h54, 4, "ras_full");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h44, 3, "ras_pop1");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h34, 2, "ras_pop2");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h24, 1, "ras_pop3");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h104, 0, "ras_pop4");
        upd(32'h20C, 32'h104, 1, 3);
        look(32'h20C, 1, 32'h104, 0, "ras_pop_empty");

        // Same-cycle update and lookup, flush with update, reset mid-training
        cyc(32'h0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 1'b0, 32'h0, 0, "flush");
        cyc(32'h40, 1, 32'h40, 32'h20, 1, 0, 0, 1, 1, 0, 32'h44, 0, "same_cycle_old");
        look(32'h40, 1, 32'h20, 0, "same_cycle_new");
        cyc(32'h80, 1, 32'h80, 32'h200, 1, 1, 1, 1, 1, 0, 32'h84, 0, "flush_upd_pre");
        look(32'h80, 0, 32'h84, 0, "flush_drop");
        look(32'h40, 0, 32'h44, 0, "flush_inval");
        upd(32'h40, 32'h20, 1, 0);
        upd(32'h100, 32'h500, 1, 2);
        cyc(32'h40, 1, 32'h40, 32'h20, 1, 0, 0, 0, 0, 1'b0, 32'h0, 0, "reset_mid");
        look(32'h40, 0, 32'h44, 0, "post_reset_miss");
        look(32'h100, 0, 32'h104, 0, "post_reset_ras");

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            int          kind;
            bit          utk;
            logic [31:0] upc;
            kind = int'($urandom_range(0, 3));
            utk  = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            upc  = rnd_pc();
            cyc(rnd_pc(), ($urandom_range(0, 3) != 0), upc, $urandom(), utk, kind,
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) != 0),
                0, 1'b0, 32'h0, 0, "rand");
        end

        @(posedge bp_clk);
        #1;
        bp_upd_valid = 1'b0; bp_flush = 1'b0; bp_reset_n = 1'b1;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge bp_clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
